mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning max consecutive cycles a requesting fetch port is denied before a forced grant (fixed-priority mode only; legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports i_req input 1 fetch read request; i_addr input 32 fetch address.
REQ-005 SHALL have ports i_gnt output 1 fetch granted this cycle; i_rvalid output 1 fetch read data valid; i_rdata output 32 fetch read data.
REQ-006 SHALL have ports d_req input 1 load/store request; d_we input 2 store size (00 load, 01 byte, 10 half, 11 word); d_addr input 32; d_wdata input 32.
REQ-007 SHALL have ports d_gnt output 1; d_rvalid output 1; d_rdata output 32, load/store side.
REQ-008 SHALL have ports m_en output 1, m_we output 2, m_addr output 32, m_wdata output 32 to the single-port memory, and m_rdata input 32 valid the cycle after an m_en read.

Function
REQ-009 SHALL assert at most one of i_gnt/d_gnt per cycle, combinationally from current requests and state, same cycle as req.
REQ-010 SHALL grant an unopposed requester immediately; requesters hold req and payload stable until granted.
REQ-011 SHALL, when both request, grant d (load/store) unless the starvation counter equals STARVE_MAX, then grant i.
REQ-012 SHALL keep a 4-bit starvation counter: +1 each cycle i_req && !i_gnt, cleared when i_gnt or !i_req, saturating at STARVE_MAX.
REQ-013 SHALL drive m_en=1 and mux m_addr/m_we/m_wdata from the winner; fetch grants force m_we=00, m_wdata=0.
REQ-014 SHALL drive m_en=0, m_we=00, m_addr=0, m_wdata=0 in cycles with no grant.
REQ-015 SHALL register read ownership (pending bit + owner) on every granted read (fetch, or d with d_we=00); stores create no pending read.
REQ-016 SHALL assert exactly one of i_rvalid/d_rvalid for one cycle, the cycle after the granted read, routing m_rdata to that port's rdata.
REQ-017 SHALL drive i_rdata/d_rdata to 0 when its rvalid is low.
REQ-018 SHALL support a new grant every cycle (fully pipelined); a grant in the cycle a previous read returns is legal and independent.

Reset
REQ-019 SHALL on rst_n low immediately clear pending read, rvalids, starvation counter, and round-robin pointer (pointing to d).
REQ-020 SHALL hold i_gnt, d_gnt, m_en low while rst_n is low.
REQ-021 SHALL discard a read granted the cycle reset asserts: no rvalid after reset release.

Configuration
REQ-022 SHALL, with MEM_ARB_RR_EN defined, replace REQ-011/REQ-012 with round-robin: 1-bit pointer, contested grant goes to pointer side, pointer flips to the other side after every grant; starvation counter and STARVE_MAX unused.
REQ-023 SHALL, without MEM_ARB_RR_EN, implement fixed d-priority with starvation escape per REQ-011/REQ-012.

Verification
REQ-024 SHALL cover: i_req=1, i_addr=0x100, d_req=0 -> i_gnt=1, m_en=1, m_addr=0x100, m_we=00; next cycle i_rvalid=1, i_rdata=m_rdata.
REQ-025 SHALL cover: d_req=1, d_we=01, d_addr=0x2003, d_wdata=0xAB with i_req=1 -> d_gnt=1, m_we=01, m_addr=0x2003; no rvalid next cycle; i_gnt=0.
REQ-026 SHALL cover (fixed mode, STARVE_MAX=4): i_req and d_req held high 6 cycles -> d_gnt cycles 0-3, i_gnt cycle 4, d_gnt cycle 5.
REQ-027 SHALL cover (MEM_ARB_RR_EN): both requesting 4 cycles from reset -> grants d, i, d, i.
REQ-028 SHALL cover: load granted (d_we=00, d_addr=0x40), rst_n low next cycle before return -> d_rvalid stays 0 during and after reset, all gnts 0 while rst_n=0.
REQ-029 SHALL cover: back-to-back fetch at 0x0 then load at 0x8 -> i_rvalid cycle 1, d_rvalid cycle 2, each with its own m_rdata.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch (i_*), load/store (d_*) and memory (m_*) signals.
//   slave  : arbiter view (takes requests and m_rdata; drives grants, read returns, memory command)
//   master : requester/memory view (drives requests and m_rdata; observes the rest)
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [1:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic [1:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch / load-store arbiter onto one single-port memory.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave -- i_* fetch req/gnt/read return, d_* load/store
//           req/gnt/read return, m_* memory command out, m_rdata in (one cycle after a read)
//   Build option MEM_ARB_RR_EN: round-robin arbitration; otherwise fixed d-priority
//   with a fetch starvation escape after STARVE_MAX (1..15) denied cycles.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    logic i_win;
    logic rd_gnt;
    logic pend;
    logic own_i;

`ifdef MEM_ARB_RR_EN
    // ptr_i=1 means fetch wins the next contested cycle; it moves away from each winner
    logic ptr_i;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_i <= 1'b0;
        else if (bus.i_gnt || bus.d_gnt) ptr_i <= bus.d_gnt;

    assign i_win = ptr_i;
`else
    logic [3:0] starve;

    // counts consecutive denied fetch cycles; i_win marks saturation at STARVE_MAX
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) starve <= 4'd0;
        else starve <= (bus.i_req && !bus.i_gnt) ? (i_win ? starve : starve + 4'd1) : 4'd0;

    assign i_win = starve == 4'(STARVE_MAX);
`endif

    always_comb begin
        bus.i_gnt    = rst_n && bus.i_req && (!bus.d_req || i_win);
        bus.d_gnt    = rst_n && bus.d_req && !bus.i_gnt;
        bus.m_en     = bus.i_gnt || bus.d_gnt;
        bus.m_we     = bus.d_gnt ? bus.d_we : 2'b00;
        bus.m_addr   = bus.i_gnt ? bus.i_addr : (bus.d_gnt ? bus.d_addr : 32'd0);
        bus.m_wdata  = bus.d_gnt ? bus.d_wdata : 32'd0;
        rd_gnt       = bus.i_gnt || (bus.d_gnt && bus.d_we == 2'b00);
        bus.i_rvalid = pend && own_i;
        bus.d_rvalid = pend && !own_i;
        bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : 32'd0;
        bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : 32'd0;
    end

    // read ownership: memory answers exactly one cycle after the granted read
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend  <= 1'b0;
            own_i <= 1'b0;
        end else begin
            pend  <= rd_gnt;
            own_i <= bus.i_gnt;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with directed cases and random traffic.
module tb_mem_arbiter;
    localparam int SM = 4;

    typedef struct {
        int          due;
        bit          is_i;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [68:0] gq[$];
    rd_t         rq[$];

    int i_wait = 0;
    bit rr_i = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // memory: read data one cycle after a read command, garbage otherwise
    always @(posedge clk)
        bus.m_rdata <= (bus.m_en && bus.m_we == 2'b00) ? mem_f(bus.m_addr) : $urandom;

    function automatic bit prefer_i();
`ifdef MEM_ARB_RR_EN
        return rr_i;
`else
        return i_wait == SM;
`endif
    endfunction

    task automatic step(input bit r, input bit ir, input logic [31:0] ia, input bit dr,
                        input logic [1:0] dw, input logic [31:0] da, input logic [31:0] dwd,
                        output bit gi, output bit gd);
        @(posedge clk);
        #1;
        rst_n       = r;
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        if (!r) begin
            gi = 0;
            gd = 0;
            i_wait = 0;
            rr_i = 0;
        end else begin
            gi = ir && (!dr || prefer_i());
            gd = dr && !gi;
            i_wait = (ir && !gi) ? ((i_wait < SM) ? i_wait + 1 : i_wait) : 0;
            if (gi || gd) rr_i = gd;
        end
        gq.push_back({gi, gd, gi | gd, gd ? dw : 2'b00,
                      gi ? ia : (gd ? da : 32'd0), gd ? dwd : 32'd0});
        if (gi || (gd && dw == 2'b00)) rq.push_back('{cyc + 1, gi, mem_f(gi ? ia : da)});
    endtask

    task automatic idle(input bit r);
        bit gi, gd;
        step(r, 0, 32'd0, 0, 2'b00, 32'd0, 32'd0, gi, gd);
    endtask

    // reset asserted late in the cycle, after that cycle's grant has been sampled
    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        rq.delete();
        i_wait = 0;
        rr_i = 0;
    endtask

    always @(negedge clk) begin
        logic [68:0] g;
        logic [68:0] a;
        rd_t         e;
        if (gq.size() != 0) begin
            g = gq.pop_front();
            a = {bus.i_gnt, bus.d_gnt, bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata};
            vectors++;
            if (a !== g) begin
                miscompares++;
                $display("FAIL grant cyc=%0d got=%h want=%h", cyc, a, g);
            end
        end
        if (bus.i_rvalid || bus.d_rvalid) begin
            vectors++;
            if (rq.size() == 0 || rq[0].due != cyc) begin
                miscompares++;
                $display("FAIL rvalid_unexpected cyc=%0d got i=%b d=%b want none", cyc, bus.i_rvalid, bus.d_rvalid);
            end else begin
                e = rq.pop_front();
                if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !==
                    {e.is_i, !e.is_i, e.is_i ? e.data : 32'd0, e.is_i ? 32'd0 : e.data}) begin
                    miscompares++;
                    $display("FAIL rdata cyc=%0d got i=%b/%h d=%b/%h want i=%b d=%b data=%h",
                             cyc, bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata, e.is_i, !e.is_i, e.data);
                end
            end
        end else begin
            if (rq.size() != 0 && rq[0].due == cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL rvalid_missing cyc=%0d got none want %s", cyc, rq[0].is_i ? "i" : "d");
                void'(rq.pop_front());
            end
            vectors++;
            if (bus.i_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin
                miscompares++;
                $display("FAIL rdata_idle cyc=%0d got i=%h d=%h want 0", cyc, bus.i_rdata, bus.d_rdata);
            end
        end
    end

    initial begin
        bit          gi, gd;
        bit          hi, hd;
        logic [31:0] ia, da, dwd;
        logic [1:0]  dw;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        // reset state with requests pending: no grants
        step(0, 1, 32'h10, 1, 2'b00, 32'h20, 32'd0, gi, gd);
        step(0, 1, 32'h10, 1, 2'b00, 32'h20, 32'd0, gi, gd);
        idle(1);
        // unopposed fetch and its read return
        step(1, 1, 32'h100, 0, 2'b00, 32'd0, 32'd0, gi, gd);
        idle(1);
        // byte store beats a fetch; fetch granted afterwards
        step(1, 1, 32'h100, 1, 2'b01, 32'h2003, 32'hAB, gi, gd);
        step(1, 1, 32'h100, 0, 2'b00, 32'd0, 32'd0, gi, gd);
        idle(1);
        // contention from reset: starvation escape or round-robin alternation
        mid_reset();
        idle(0);
        for (int k = 0; k < 6; k++)
            step(1, 1, 32'h300, 1, 2'b00, 32'h400 + 32'(4 * k), 32'd0, gi, gd);
        idle(1);
        // back-to-back fetch then load
        step(1, 1, 32'h0, 0, 2'b00, 32'd0, 32'd0, gi, gd);
        step(1, 0, 32'd0, 1, 2'b00, 32'h8, 32'd0, gi, gd);
        idle(1);
        idle(1);
        // load granted, reset in the same cycle: read discarded
        step(1, 0, 32'd0, 1, 2'b00, 32'h40, 32'd0, gi, gd);
        mid_reset();
        step(0, 1, 32'h50, 1, 2'b00, 32'h60, 32'd0, gi, gd);
        step(0, 1, 32'h50, 1, 2'b00, 32'h60, 32'd0, gi, gd);
        idle(1);
        idle(1);
        // random traffic; payload held until granted
        hi = 0; hd = 0; ia = 0; da = 0; dw = 0; dwd = 0;
        for (int k = 0; k < 2000; k++) begin
            if (!hi) begin
                hi = $urandom_range(0, 99) < 60;
                ia = $urandom;
            end
            if (!hd) begin
                hd = $urandom_range(0, 99) < 70;
                da = $urandom;
                dw = 2'($urandom_range(0, 3));
                dwd = $urandom;
            end
            step(1, hi, ia, hd, dw, da, dwd, gi, gd);
            if (gi) hi = 0;
            if (gd) hd = 0;
        end
        idle(1);
        idle(1);
        idle(1);
        @(posedge clk);
        #1;
        vectors++;
        if (rq.size() != 0 || gq.size() != 0) begin
            miscompares++;
            $display("FAIL drain got rq=%0d gq=%0d want 0 0", rq.size(), gq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
